aes_core_scheduler: RTL and testbench

Round-robin scheduler that shares one AES_core instance between NUM_REQ requesters.
- Each requester submits a job (key, keylen, encdec, block) over a valid/ready handshake.
- The scheduler latches the winning job, sequences core init (key expansion) then next (block processing), and returns the 128-bit result to the owning requester over a valid/ready response handshake.
- It sits between the host-side register front end and AES_core, replacing direct init/next strobing.

---
 rtl/aes_core_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_aes_core_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_scheduler.sv
// Round-robin scheduler sharing one AES core between NUM_REQ requesters.
// Optional macro KEY_CACHE_EN skips key expansion when the key matches the last expanded one.
`timescale 1ns/1ps
module aes_core_scheduler #(
    parameter int NUM_REQ = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_encdec,
    input  logic [NUM_REQ-1:0]     req_keylen,
    input  logic [NUM_REQ*256-1:0] req_key,
    input  logic [NUM_REQ*128-1:0] req_block,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [127:0]           rsp_result,
    output logic                   busy,
    output logic                   core_encdec,
    output logic                   core_keylen,
    output logic [255:0]           core_key,
    output logic [127:0]           core_block,
    output logic                   core_init,
    output logic                   core_next,
    input  logic                   core_ready,
    input  logic [127:0]           core_result,
    input  logic                   core_result_valid
);

    localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT      = 3'd1,
        INIT_WAIT = 3'd2,
        NEXT      = 3'd3,
        NEXT_WAIT = 3'd4,
        RESP      = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        own_q, own_d;
    logic                 encdec_q, encdec_d;
    logic                 keylen_q, keylen_d;
    logic [255:0]         key_q, key_d;
    logic [127:0]         block_q, block_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [127:0]         rsp_result_q, rsp_result_d;
    logic                 skip_q, skip_d;

    logic                 found;
    logic [PW-1:0]        win;
    logic [PW-1:0]        idx;
    logic                 win_encdec;
    logic                 win_keylen;
    logic [255:0]         win_key;
    logic [127:0]         win_block;
    logic                 cache_hit;

    // Handshakes: a job is taken when the scheduler samples req_valid[i] in IDLE;
    // req_ready[i] is a registered one-cycle acknowledge the cycle after, so the
    // requester holds valid and its job fields until it sees ready. A response
    // transfers in the cycle where rsp_valid[i] and rsp_ready[i] are both high.

    // First pending requester at or after the priority pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_encdec = 1'b0;
        win_keylen = 1'b0;
        win_key    = '0;
        win_block  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == PW'(i)) begin
                win_encdec = req_encdec[i];
                win_keylen = req_keylen[i];
                win_key    = req_key[256*i +: 256];
                win_block  = req_block[128*i +: 128];
            end
        end
    end

`ifdef KEY_CACHE_EN
    logic [255:0] last_key_q, last_key_d;
    logic         last_keylen_q, last_keylen_d;
    logic         cache_vld_q, cache_vld_d;
    logic         init_done;

    assign init_done = (state_q == INIT_WAIT) && !skip_q && core_ready;
    assign cache_hit = cache_vld_q && (last_key_q == win_key) && (last_keylen_q == win_keylen);

    always_comb begin
        last_key_d    = last_key_q;
        last_keylen_d = last_keylen_q;
        cache_vld_d   = cache_vld_q;
        if (init_done) begin
            last_key_d    = key_q;
            last_keylen_d = keylen_q;
            cache_vld_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key_q    <= '0;
            last_keylen_q <= 1'b0;
            cache_vld_q   <= 1'b0;
        end else begin
            last_key_q    <= last_key_d;
            last_keylen_q <= last_keylen_d;
            cache_vld_q   <= cache_vld_d;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        own_d        = own_q;
        encdec_d     = encdec_q;
        keylen_d     = keylen_q;
        key_d        = key_q;
        block_d      = block_q;
        req_ready_d  = '0;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        skip_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (found && core_ready) begin
                    req_ready_d[win] = 1'b1;
                    own_d            = win;
                    encdec_d         = win_encdec;
                    keylen_d         = win_keylen;
                    key_d            = win_key;
                    block_d          = win_block;
                    state_d          = cache_hit ? NEXT : INIT;
                end
            end
            INIT: begin
                skip_d  = 1'b1;
                state_d = INIT_WAIT;
            end
            // The core lowers ready one cycle after a strobe, so the first wait cycle is blind.
            INIT_WAIT: begin
                if (!skip_q && core_ready) state_d = NEXT;
            end
            NEXT: begin
                skip_d  = 1'b1;
                state_d = NEXT_WAIT;
            end
            NEXT_WAIT: begin
                if (!skip_q && core_ready && core_result_valid) begin
                    rsp_result_d       = core_result;
                    rsp_valid_d[own_q] = 1'b1;
                    state_d            = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[own_q]) begin
                    rsp_valid_d = '0;
                    ptr_d       = (own_q == PW'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            own_q        <= '0;
            encdec_q     <= 1'b0;
            keylen_q     <= 1'b0;
            key_q        <= '0;
            block_q      <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            skip_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            own_q        <= own_d;
            encdec_q     <= encdec_d;
            keylen_q     <= keylen_d;
            key_q        <= key_d;
            block_q      <= block_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            skip_q       <= skip_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign busy        = (state_q != IDLE);
    assign core_encdec = encdec_q;
    assign core_keylen = keylen_q;
    assign core_key    = key_q;
    assign core_block  = block_q;
    assign core_init   = (state_q == INIT);
    assign core_next   = (state_q == NEXT);

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed bench for aes_core_scheduler with a behavioural stand-in for AES_core.
// Covers reset, single job, contention, backpressure, mid-job reset, strobe timing, key cache.
`timescale 1ns/1ps
module tb_aes_core_scheduler;

    localparam int N = 2;
    localparam int TMO = 300;

    localparam logic [255:0] K_FIPS = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] B_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     req_encdec = '0;
    logic [N-1:0]     req_keylen = '0;
    logic [N*256-1:0] req_key = '0;
    logic [N*128-1:0] req_block = '0;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready = '0;
    logic [127:0]     rsp_result;
    logic             busy;
    logic             core_encdec, core_keylen, core_init, core_next;
    logic [255:0]     core_key;
    logic [127:0]     core_block;

    // core stand-in state
    logic             c_ready, c_rv, lag, was_next, c_kl;
    logic [127:0]     c_res;
    logic [255:0]     c_key;
    int               cnt;
    int               core_lat = 3;
    bit               core_nodrop = 1'b0;

    int errors = 0;
    int checks = 0;
    int n_init = 0, n_next = 0, n_grant = 0, gap = 100, next_gap = 0;
    int onehot_viol = 0, strobe_viol = 0;

    always #5 clk = ~clk;

    aes_core_scheduler #(.NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_encdec(req_encdec),
        .req_keylen(req_keylen), .req_key(req_key), .req_block(req_block),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .busy(busy), .core_encdec(core_encdec), .core_keylen(core_keylen),
        .core_key(core_key), .core_block(core_block), .core_init(core_init),
        .core_next(core_next), .core_ready(c_ready), .core_result(c_res),
        .core_result_valid(c_rv)
    );

    // Stand-in result: the real AES value for the FIPS-197 vector, a simple mix otherwise.
    function automatic logic [127:0] core_fn(logic [255:0] k, logic kl, logic ed, logic [127:0] b);
        logic [127:0] r;
        if (k == K_FIPS && !kl && ed && b == B_FIPS) return R_FIPS;
        r = b ^ k[255:128] ^ k[127:0] ^ {128{kl}};
        if (!ed) r = ~r;
        return r;
    endfunction

    // Core stand-in: ready falls one cycle after a strobe, stays low core_lat cycles.
    // Key is captured at init and reused by later next strobes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_ready <= 1'b1; c_rv <= 1'b0; c_res <= '0; lag <= 1'b0; cnt <= 0;
            was_next <= 1'b0; c_key <= '0; c_kl <= 1'b0;
        end else if (core_init || core_next) begin
            if (lag || !c_ready) strobe_viol <= strobe_viol + 1;
            lag <= 1'b1; was_next <= core_next; c_rv <= 1'b0;
            if (core_init) begin
                c_key <= core_key; c_kl <= core_keylen;
            end else begin
                c_res <= core_fn(c_key, c_kl, core_encdec, core_block);
            end
        end else if (lag) begin
            lag <= 1'b0;
            if (core_nodrop) c_rv <= was_next;
            else begin c_ready <= 1'b0; cnt <= core_lat; end
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin c_ready <= 1'b1; c_rv <= was_next; end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (core_init) gap = 0;
            else if (gap < 100) gap = gap + 1;
            if (core_init) n_init = n_init + 1;
            if (core_next) begin n_next = n_next + 1; next_gap = gap; end
            if (|req_ready) n_grant = n_grant + 1;
            if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) onehot_viol = onehot_viol + 1;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_job(input int r, input logic [255:0] k, input logic kl, input logic ed,
                           input logic [127:0] b);
        req_key[256*r +: 256] = k;
        req_keylen[r] = kl;
        req_encdec[r] = ed;
        req_block[128*r +: 128] = b;
        req_valid[r] = 1'b1;
    endtask

    task automatic wait_accept(input int r, input string name);
        int i;
        for (i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (req_ready[r]) break;
        end
        checks++;
        if (i == TMO) begin
            errors++;
            $display("FAIL %s accept: req_ready[%0d] never pulsed, required a pulse", name, r);
        end
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(input int r, input logic [127:0] exp, input string name);
        int i;
        for (i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (rsp_valid[r]) break;
        end
        checks++;
        if (i == TMO) begin
            errors++;
            $display("FAIL %s rsp timeout: rsp_valid=%b, required bit %0d", name, rsp_valid, r);
            return;
        end
        checks++;
        if (rsp_result !== exp) begin
            errors++;
            $display("FAIL %s result: got %h required %h", name, rsp_result, exp);
        end
        rsp_ready[r] = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== '0) begin
            errors++;
            $display("FAIL %s rsp clear: rsp_valid=%b required 00", name, rsp_valid);
        end
        rsp_ready[r] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11; rsp_ready = 2'b11;
        req_key = {512{1'b1}}; req_block = {256{1'b1}}; req_encdec = 2'b11; req_keylen = 2'b11;
        repeat (3) @(negedge clk);
        checks += 6;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL reset req_ready: got %b required 00", req_ready); end
        if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset rsp_valid: got %b required 00", rsp_valid); end
        if (rsp_result !== '0) begin errors++; $display("FAIL reset rsp_result: got %h required 0", rsp_result); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
        if ({core_init, core_next, core_encdec, core_keylen} !== 4'b0) begin
            errors++; $display("FAIL reset core strobes: got %b required 0000", {core_init, core_next, core_encdec, core_keylen});
        end
        if (core_key !== '0 || core_block !== '0) begin
            errors++; $display("FAIL reset core data: key %h block %h required 0", core_key, core_block);
        end
        req_valid = '0; rsp_ready = '0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle busy: got %b required 0", busy); end
    endtask

    task automatic test_single_job();
        int i0, x0, g0, i;
        i0 = n_init; x0 = n_next; g0 = n_grant;
        set_job(0, K_FIPS, 1'b0, 1'b1, B_FIPS);
        wait_accept(0, "single");
        checks += 3;
        if (core_key !== K_FIPS || core_block !== B_FIPS) begin
            errors++; $display("FAIL single core data: key %h block %h", core_key, core_block);
        end
        if ({core_encdec, core_keylen} !== 2'b10) begin
            errors++; $display("FAIL single core mode: got %b required 10", {core_encdec, core_keylen});
        end
        if (busy !== 1'b1) begin errors++; $display("FAIL single busy: got %b required 1", busy); end
        for (i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (rsp_valid[0]) break;
        end
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            checks += 2;
            if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single hold valid: got %b required 01", rsp_valid); end
            if (rsp_result !== R_FIPS) begin errors++; $display("FAIL single hold result: got %h required %h", rsp_result, R_FIPS); end
        end
        wait_rsp(0, R_FIPS, "single");
        checks += 4;
        if (n_init - i0 !== 1) begin errors++; $display("FAIL single init count: got %0d required 1", n_init - i0); end
        if (n_next - x0 !== 1) begin errors++; $display("FAIL single next count: got %0d required 1", n_next - x0); end
        if (n_grant - g0 !== 1) begin errors++; $display("FAIL single grant count: got %0d required 1", n_grant - g0); end
        if (busy !== 1'b0) begin errors++; $display("FAIL single busy after: got %b required 0", busy); end
    endtask

    task automatic test_contention();
        logic [255:0] k [2];
        logic [127:0] b [2];
        logic kl [2];
        logic ed [2];
        int g, i;
        k[0] = {128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 128'h11111111222222223333333344444444};
        k[1] = {128'hdeadbeefcafef00d0123456789abcdef, 128'h0};
        b[0] = 128'h00000000000000000000000000000001;
        b[1] = 128'hffeeddccbbaa99887766554433221100;
        kl[0] = 1'b1; kl[1] = 1'b0; ed[0] = 1'b1; ed[1] = 1'b0;
        do_reset();
        set_job(0, k[0], kl[0], ed[0], b[0]);
        set_job(1, k[1], kl[1], ed[1], b[1]);
        for (int n = 0; n < 4; n++) begin
            for (i = 0; i < TMO; i++) begin
                @(negedge clk);
                if (|req_ready) break;
            end
            g = req_ready[1] ? 1 : 0;
            checks++;
            if (i == TMO || g != n % 2) begin
                errors++; $display("FAIL contention grant %0d: got req_ready=%b required requester %0d", n, req_ready, n % 2);
            end
            wait_rsp(g, core_fn(k[g], kl[g], ed[g], b[g]), "contention");
            if (n == 3) req_valid = '0;
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] k;
        logic [127:0] b, exp;
        int g0, i;
        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        b = 128'h6bc1bee22e409f96e93d7e117393172a;
        exp = core_fn(k, 1'b0, 1'b1, b);
        set_job(1, k, 1'b0, 1'b1, b);
        wait_accept(1, "backpressure");
        set_job(0, k, 1'b0, 1'b0, ~b);
        for (i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (rsp_valid[1]) break;
        end
        rsp_ready = 2'b01;
        g0 = n_grant;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks += 3;
            if (rsp_valid !== 2'b10) begin errors++; $display("FAIL backpressure valid c%0d: got %b required 10", c, rsp_valid); end
            if (rsp_result !== exp) begin errors++; $display("FAIL backpressure result c%0d: got %h required %h", c, rsp_result, exp); end
            if (busy !== 1'b1) begin errors++; $display("FAIL backpressure busy c%0d: got %b required 1", c, busy); end
        end
        checks++;
        if (n_grant != g0) begin errors++; $display("FAIL backpressure grants: got %0d required 0", n_grant - g0); end
        rsp_ready = 2'b00;
        wait_rsp(1, exp, "backpressure");
        wait_accept(0, "backpressure follow");
        wait_rsp(0, core_fn(k, 1'b0, 1'b0, ~b), "backpressure follow");
    endtask

    task automatic test_mid_reset();
        logic [255:0] k;
        logic [127:0] b;
        int i;
        k = {128'h55555555aaaaaaaa55555555aaaaaaaa, 128'h0};
        b = 128'h0123456789abcdeffedcba9876543210;
        set_job(0, k, 1'b0, 1'b1, b);
        wait_accept(0, "midreset");
        for (i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (core_next) break;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
            errors++; $display("FAIL midreset flags: busy %b rsp_valid %b req_ready %b required 0", busy, rsp_valid, req_ready);
        end
        if ({core_init, core_next} !== 2'b00) begin errors++; $display("FAIL midreset strobes: got %b required 00", {core_init, core_next}); end
        if (core_key !== '0 || core_block !== '0 || rsp_result !== '0) begin
            errors++; $display("FAIL midreset data: key %h block %h result %h required 0", core_key, core_block, rsp_result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00) begin errors++; $display("FAIL midreset stale rsp: got %b required 00", rsp_valid); end
        set_job(1, k, 1'b1, 1'b0, ~b);
        wait_accept(1, "midreset after");
        wait_rsp(1, core_fn(k, 1'b1, 1'b0, ~b), "midreset after");
    endtask

    task automatic test_strobe_timing();
        logic [255:0] k;
        logic [127:0] b;
        int x0;
        k = {128'h8e73b0f7da0e6452c810f32b809079e5, 128'h62f8ead2522c6b7bf2b7b1a1ad8d7a46};
        b = 128'h3243f6a8885a308d313198a2e0370734;
        core_nodrop = 1'b1;
        x0 = n_next;
        set_job(0, k, 1'b1, 1'b1, b);
        wait_accept(0, "strobe");
        wait_rsp(0, core_fn(k, 1'b1, 1'b1, b), "strobe");
        checks += 2;
        if (n_next - x0 !== 1) begin errors++; $display("FAIL strobe next count: got %0d required 1", n_next - x0); end
        if (next_gap !== 3) begin errors++; $display("FAIL strobe init-to-next gap: got %0d required 3", next_gap); end
        core_nodrop = 1'b0;
    endtask

    task automatic test_key_cache();
        logic [255:0] ka, kb;
        int i0, exp_hit_inits;
`ifdef KEY_CACHE_EN
        exp_hit_inits = 0;
`else
        exp_hit_inits = 1;
`endif
        ka = {128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4};
        kb = ka ^ {255'h0, 1'b1};
        do_reset();
        i0 = n_init;
        set_job(0, ka, 1'b1, 1'b1, 128'h1);
        wait_accept(0, "cache first");
        wait_rsp(0, core_fn(ka, 1'b1, 1'b1, 128'h1), "cache first");
        checks++;
        if (n_init - i0 !== 1) begin errors++; $display("FAIL cache first init: got %0d required 1", n_init - i0); end
        i0 = n_init;
        set_job(1, ka, 1'b1, 1'b0, 128'h2);
        wait_accept(1, "cache same");
        wait_rsp(1, core_fn(ka, 1'b1, 1'b0, 128'h2), "cache same");
        checks++;
        if (n_init - i0 !== exp_hit_inits) begin
            errors++; $display("FAIL cache same key init: got %0d required %0d", n_init - i0, exp_hit_inits);
        end
        i0 = n_init;
        set_job(0, kb, 1'b1, 1'b1, 128'h3);
        wait_accept(0, "cache changed");
        wait_rsp(0, core_fn(kb, 1'b1, 1'b1, 128'h3), "cache changed");
        checks++;
        if (n_init - i0 !== 1) begin errors++; $display("FAIL cache changed key init: got %0d required 1", n_init - i0); end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_contention();
        test_backpressure();
        test_mid_reset();
        test_strobe_timing();
        test_key_cache();
        checks += 2;
        if (onehot_viol !== 0) begin errors++; $display("FAIL onehot: %0d cycles with multiple bits, required 0", onehot_viol); end
        if (strobe_viol !== 0) begin errors++; $display("FAIL core strobe while busy: %0d strobes, required 0", strobe_viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
